// File: rtl/osc_sample_ram_if.sv
// osc_sample_ram_if: Avalon-MM s1 bus bundle for the CPU side of osc_sample_ram
//   address/chipselect/read/write/writedata/byteenable : s1 command (master -> slave)
//   clken/reset_req : s1 clock enable and reset request (master -> slave)
//   readdata/readdatavalid : s1 read response (slave -> master)
interface osc_sample_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    clken;
  logic                    reset_req;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  modport master (
    output address, chipselect, read, write, writedata, byteenable, clken, reset_req,
    input  readdata, readdatavalid
  );
  modport slave (
    input  address, chipselect, read, write, writedata, byteenable, clken, reset_req,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/osc_sample_ram.sv
// osc_sample_ram: dual-port scope capture RAM (CPU Avalon-MM s1 port + circular capture port)
//   clk, reset_n      : single clock, asynchronous active-low reset
//   s1                : Avalon-MM slave (see osc_sample_ram_if), byte-lane writes, pipelined reads
//   cap_arm           : pulse to (re)start capture from address 0
//   cap_valid/cap_data: sample stream written into the circular buffer
//   cap_trigger       : marks the current sample as the trigger sample
//   post_count        : samples kept after the trigger, latched at trigger time
//   cap_busy/cap_done : capture in progress / capture finished
//   cap_wrapped       : write pointer wrapped since the last arm
//   cap_trig_addr     : buffer address of the trigger sample
//   cap_wr_addr       : next capture write address
module osc_sample_ram #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 16,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = "osc_sample_ram.hex"
) (
  input  logic                  clk,
  input  logic                  reset_n,
  osc_sample_ram_if.slave       s1,
  input  logic                  cap_arm,
  input  logic                  cap_valid,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  cap_trigger,
  input  logic [ADDR_WIDTH-1:0] post_count,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic                  cap_wrapped,
  output logic [ADDR_WIDTH-1:0] cap_trig_addr,
  output logic [ADDR_WIDTH-1:0] cap_wr_addr
);
  localparam int NB = DATA_WIDTH / 8;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_trig_addr, r_cnt;
  logic                  r_wrapped;
  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  w_s1_en, w_s1_we, w_s1_rd, w_cap_we, w_s1_drop;
  assign w_s1_en   = s1.clken & ~s1.reset_req;
  assign w_s1_we   = w_s1_en & s1.chipselect & s1.write;
  assign w_s1_rd   = w_s1_en & s1.chipselect & s1.read & ~s1.write;
  // arm takes priority over a coincident sample, so that sample is never stored
  assign w_cap_we  = ~cap_arm & cap_valid & (r_state == S_ARMED || r_state == S_POST);
  // capture port owns the address on a collision; the CPU write is discarded whole
  assign w_s1_drop = w_cap_we && (r_wr_addr == s1.address);
  // contents are never reset; reads see the pre-write word (read-first)
  always_ff @(posedge clk) begin
    if (w_cap_we) r_mem[r_wr_addr] <= cap_data;
    if (w_s1_we && !w_s1_drop)
      for (int b = 0; b < NB; b++)
        if (s1.byteenable[b]) r_mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
  end
  // whole read pipeline freezes while s1 is disabled, so no result is lost or repeated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else if (w_s1_en) begin
      r_v1 <= w_s1_rd;
      if (w_s1_rd) r_d1 <= r_mem[s1.address];
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_d2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else if (w_s1_en) begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end
    assign s1.readdatavalid = r_v2;
    assign s1.readdata      = r_d2;
  end else begin : g_noreg
    assign s1.readdatavalid = r_v1;
    assign s1.readdata      = r_d1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    if (cap_arm)
      w_state_nx = S_ARMED;
    else if (w_cap_we && r_state == S_ARMED && cap_trigger)
      w_state_nx = (post_count == '0) ? S_DONE : S_POST;
    else if (w_cap_we && r_state == S_POST && r_cnt == ADDR_WIDTH'(1))
      w_state_nx = S_DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_addr   <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_wrapped   <= 1'b0;
    end else if (cap_arm) begin
      r_wr_addr   <= '0;
      r_trig_addr <= '0;
      r_cnt       <= '0;
      r_wrapped   <= 1'b0;
    end else if (w_cap_we) begin
      r_wr_addr <= r_wr_addr + 1'b1;
      r_wrapped <= r_wrapped | (&r_wr_addr);
      if (r_state == S_ARMED && cap_trigger) begin
        r_trig_addr <= r_wr_addr;
        r_cnt       <= post_count;
      end
      if (r_state == S_POST) r_cnt <= r_cnt - 1'b1;
    end
  end
  assign cap_busy      = (r_state == S_ARMED) || (r_state == S_POST);
  assign cap_done      = (r_state == S_DONE);
  assign cap_wrapped   = r_wrapped;
  assign cap_trig_addr = r_trig_addr;
  assign cap_wr_addr   = r_wr_addr;
endmodule

// File: doc/osc_sample_ram.md
Name: osc_sample_ram

Overview:
- Parametrised successor to the single-port 8-bit on-chip RAM.
- Dual-port capture memory with configurable width, depth and read latency.
- Port A: CPU-side Avalon-MM slave (s1) with byte enables and readdatavalid.
- Port B: scope-side streaming capture port. Fills a circular buffer continuously once armed, records the trigger address, stops after a programmable post-trigger count, and exposes status for the CPU to read the trace back.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 16, word address width; depth = 2^ADDR_WIDTH.
OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2.
INIT_FILE, "osc_sample_ram.hex", memory init file (no reset of contents).

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  s1 word address
chipselect  in  1  s1 select
read  in  1  s1 read strobe
write  in  1  s1 write strobe
writedata  in  DATA_WIDTH  s1 write data
byteenable  in  DATA_WIDTH/8  s1 byte lanes for writes
clken  in  1  s1 clock enable
reset_req  in  1  s1 reset request; holds s1 port like clken=0
readdata  out  DATA_WIDTH  s1 read data
readdatavalid  out  1  readdata valid strobe
cap_arm  in  1  one-cycle pulse: start/restart capture
cap_valid  in  1  cap_data is a sample this cycle
cap_data  in  DATA_WIDTH  sample word
cap_trigger  in  1  qualifies the sample presented with cap_valid as the trigger sample
post_count  in  ADDR_WIDTH  samples to store after the trigger sample; sampled at trigger
cap_busy  out  1  state is ARMED or POST
cap_done  out  1  state is DONE
cap_wrapped  out  1  write pointer has wrapped since the last arm
cap_trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample
cap_wr_addr  out  ADDR_WIDTH  next capture write address

Behaviour:
Reset:
- Asynchronous reset_n=0 forces state IDLE.
- readdata, readdatavalid, all cap_* outputs and the internal post counter go to 0.
- The read pipeline is flushed.
- RAM contents are untouched.

s1 clock enable:
- s1_en = clken & ~reset_req.

s1 write:
- When s1_en & chipselect & write, write the enabled byte lanes of writedata to address.
- Lanes with byteenable=0 are unchanged.

s1 read:
- Accepted when s1_en & chipselect & read & ~write.
- readdatavalid pulses exactly OUT_REG+1 s1_en cycles after acceptance, with readdata = word at address.
- Back-to-back reads give one result per cycle.
- When s1_en=0 the read pipeline (including readdatavalid) holds. No result is dropped or duplicated.
- readdata holds its last value when readdatavalid=0.
- Read-during-write to the same address from port A returns the old data.

Capture FSM (not gated by clken):
- IDLE: ignore cap_valid and cap_trigger.
- cap_arm, from any state -> ARMED; cap_wr_addr=0, cap_wrapped=0, cap_trig_addr=0.
- ARMED: each cap_valid writes cap_data to cap_wr_addr and increments the pointer modulo 2^ADDR_WIDTH.
  - Pointer passing 2^ADDR_WIDTH-1 -> 0 sets cap_wrapped.
  - If cap_trigger=1 with cap_valid: cap_trig_addr = that sample's address and count = post_count.
  - Then go to DONE if post_count=0, else POST.
  - cap_trigger without cap_valid is ignored.
- POST: each cap_valid writes the sample, advances the pointer and decrements count. Go to DONE on the write that takes count to 0. cap_trigger is ignored.
- DONE: no writes. Hold all status until cap_arm.
- cap_arm in the same cycle as cap_valid/cap_trigger: arm wins; that sample is not written.
- Port-collision (capture write and s1 write to the same address in the same cycle): the capture write wins. The s1 write is dropped.
- s1 reads of an address being capture-written return the old data.

Test Plan:
1. OUT_REG=0 then OUT_REG=1; write 0xA5 @0x0010, read @0x0010 -> readdatavalid exactly 1 (resp. 2) cycles later with 0xA5; 4 back-to-back reads -> 4 consecutive valid cycles.
2. DATA_WIDTH=32: write 0x11223344, then write 0xAABBCCDD with byteenable=4'b0101 -> readback 0x11BB33DD.
3. Read issued, clken low 3 cycles mid-pipeline -> readdatavalid delayed by 3, single pulse, correct data; reset_req=1 behaves identically.
4. ADDR_WIDTH=4: arm, 20 samples 0..19, trigger on sample 17, post_count=2 -> cap_trig_addr=1, cap_wrapped=1, DONE after sample 19; cap_wr_addr=4; RAM[1]=17, RAM[3]=19, RAM[4]=4.
5. Trigger with post_count=0 -> DONE the next cycle, only the trigger sample written; extra cap_valid in DONE writes nothing; cap_arm then restarts with cap_wr_addr=0 and cap_done=0.
6. cap_arm during POST, and cap_arm coincident with cap_valid+cap_trigger -> ARMED, pointer 0, coincident sample not written; reset_n pulsed low mid-POST -> IDLE with all outputs 0 immediately (asynchronous).
